// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
//   Runs an internal Johnson (twisted-ring) counter through a programmed
//   number of full revolutions, then stops. A host starts a run with
//   start/rev_count and gets a one-cycle done pulse when the run completes.
//   The ring never free-runs: outside a run it sits at all-zero.
//
// Parameters
//   WIDTH  ring length in flops; one revolution is 2*WIDTH states
//   CNT_W  width of the revolution counter and rev_count
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request a run (sampled only while idle)
//   pause      in   freeze ring and revolution counter while running
//   rev_count  in   revolutions to run, sampled together with start
//   busy       out  high for every cycle of a run, paused cycles included
//   done       out  one-cycle completion pulse (also for a zero-count start)
//   ring       out  current Johnson code
//   phase      out  one-hot decode of the ring, all-zero when not busy
//   ring_err   out  sticky flag: an illegal ring code was seen and repaired
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic [CNT_W-1:0]     rev_count,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     ring,
  output logic [2*WIDTH-1:0]   phase,
  output logic                 ring_err
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_ring;
  logic [CNT_W-1:0]   r_rem;
  logic               r_done;
  logic               r_err;

  logic [2*WIDTH-1:0] w_match;
  logic               w_legal;
  logic [WIDTH-1:0]   w_next;

  // Johnson state idx: idx leading ones (from the MSB) for idx <= WIDTH,
  // otherwise 2*WIDTH-idx trailing ones.
  function automatic logic [WIDTH-1:0] johnson_code(input int idx);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (idx <= WIDTH) c[b] = (b >= WIDTH - idx);
      else              c[b] = (b < 2*WIDTH - idx);
    end
    return c;
  endfunction

  // Compare the ring against every legal code; the match vector doubles as
  // the phase decode and its OR is the legality check.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < 2*WIDTH; i++) begin
      w_match[i] = (r_ring == johnson_code(i));
    end
  end

  assign w_legal = |w_match;
  assign w_next  = {~r_ring[0], r_ring[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ring  <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ring <= '0;
          if (start) begin
            if (rev_count != '0) begin
              r_rem   <= rev_count;
              r_state <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!w_legal) begin
            // Repair to the start of a revolution; this is not a wrap, so
            // the remaining count is left alone. Repair ignores pause.
            r_ring <= '0;
            r_err  <= 1'b1;
          end else if (!pause) begin
            r_ring <= w_next;
            // Only a shift out of 0..01 lands on all-zero: one revolution.
            if (w_next == '0) begin
              r_rem <= r_rem - CNT_W'(1);
              if (r_rem == CNT_W'(1)) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign ring     = r_ring;
  assign phase    = busy ? w_match : '0;
  assign ring_err = r_err;

endmodule
